// File: rtl/depth_pkg.sv
// Shared types and constants for the stereo disparity sweep controller.
package depth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT
    } state_t;

    localparam int DEF_MAX_DISP = 10;
    localparam int H_W = 11;
    localparam int V_W = 10;

endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of SAD results; ties keep the earlier (smaller) offset.
module sad_min_tracker #(
    parameter int SAD_W = 16,
    parameter int OFF_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             update,
    input  logic [SAD_W-1:0] value,
    input  logic [OFF_W-1:0] offset,
    output logic [SAD_W-1:0] best_sad,
    output logic [OFF_W-1:0] best_off
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            best_sad <= '1;
            best_off <= '0;
        end else if (update && (value < best_sad)) begin
            best_sad <= value;
            best_off <= offset;
        end
    end

endmodule

// File: rtl/disparity_sweep_ctrl.sv
// Sweeps the SAD engine over candidate offsets per pixel and emits a depth byte.
module disparity_sweep_ctrl
    import depth_pkg::*;
#(
    parameter int HRES        = 640,
    parameter int VRES        = 360,
    parameter int MAX_DISP    = DEF_MAX_DISP,
    parameter int SAD_W       = 16,
    parameter int DEPTH_SCALE = 25
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        job_valid_in,
    output logic                        job_ready_out,
    input  logic [10:0]                 hcount_in,
    input  logic [9:0]                  vcount_in,
    output logic                        sad_start_out,
    output logic [$clog2(MAX_DISP)-1:0] sad_offset_out,
    output logic [10:0]                 sad_hcount_out,
    output logic [9:0]                  sad_vcount_out,
    input  logic                        sad_done_in,
    input  logic [SAD_W-1:0]            sad_value_in,
    output logic                        data_valid_out,
    output logic [7:0]                  pixel_depth_out,
    output logic [10:0]                 hcount_out,
    output logic [9:0]                  vcount_out,
    output logic                        err_out
);

    localparam int OFF_W = $clog2(MAX_DISP);
    localparam int CNT_W = OFF_W + 1;

    state_t             state;
    logic [CNT_W-1:0]   offset;
    logic [CNT_W-1:0]   nxt_off;
    logic               nxt_ok;
    logic               accept;
    logic               upd;
    logic [SAD_W-1:0]   best_sad;
    logic [OFF_W-1:0]   best_off;
    logic [15:0]        prod;
    logic [7:0]         depth;

    assign accept  = (state == IDLE) && job_valid_in && job_ready_out;
    assign upd     = (state == WAIT) && sad_done_in;
    assign nxt_off = offset + 1'b1;

    // Next offset must stay in range and keep the right-image column x-d >= 0.
    assign nxt_ok = (nxt_off < CNT_W'(MAX_DISP))
                 && (H_W'(nxt_off) <= sad_hcount_out);

    assign prod  = 16'(best_off) * 16'(DEPTH_SCALE);
    assign depth = (prod > 16'd255) ? 8'hFF : prod[7:0];

    sad_min_tracker #(
        .SAD_W (SAD_W),
        .OFF_W (OFF_W)
    ) u_tracker (
        .clk      (clk_in),
        .rst      (rst_in),
        .init     (accept),
        .update   (upd),
        .value    (sad_value_in),
        .offset   (OFF_W'(offset)),
        .best_sad (best_sad),
        .best_off (best_off)
    );

    // sad_start_out is registered on entry to ISSUE, so ISSUE is the request cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            offset          <= '0;
            job_ready_out   <= 1'b1;
            sad_start_out   <= 1'b0;
            sad_offset_out  <= '0;
            sad_hcount_out  <= '0;
            sad_vcount_out  <= '0;
            data_valid_out  <= 1'b0;
            pixel_depth_out <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            err_out         <= 1'b0;
        end else begin
            sad_start_out  <= 1'b0;
            data_valid_out <= 1'b0;
            if (sad_done_in && (state != WAIT))
                err_out <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sad_hcount_out <= hcount_in;
                        sad_vcount_out <= vcount_in;
                        offset         <= '0;
                        sad_offset_out <= '0;
                        sad_start_out  <= 1'b1;
                        job_ready_out  <= 1'b0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sad_start_out) begin
                        state <= WAIT;
                    end else begin
                        data_valid_out  <= 1'b1;
                        pixel_depth_out <= depth;
                        hcount_out      <= sad_hcount_out;
                        vcount_out      <= sad_vcount_out;
                        state           <= EMIT;
                    end
                end
                WAIT: begin
                    if (sad_done_in) begin
                        offset <= nxt_off;
                        if (nxt_ok) begin
                            sad_start_out  <= 1'b1;
                            sad_offset_out <= OFF_W'(nxt_off);
                        end
                        state <= ISSUE;
                    end
                end
                EMIT: begin
                    job_ready_out <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disparity_sweep_ctrl.sv
// Randomized bench for disparity_sweep_ctrl with a behavioural sweep model.
module tb_disparity_sweep_ctrl;

    localparam int MAXD   = 10;
    localparam int SCALE  = 25;
    localparam int SCALE2 = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready, job_ready2;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        sad_start, sad_start2;
    logic [3:0]  sad_offset, sad_offset2;
    logic [10:0] sad_hcount, sad_hcount2;
    logic [9:0]  sad_vcount, sad_vcount2;
    logic        sad_done = 1'b0;
    logic [15:0] sad_value = '0;
    logic        dv, dv2;
    logic [7:0]  depth, depth2;
    logic [10:0] hout, hout2;
    logic [9:0]  vout, vout2;
    logic        err, err2;

    always #5 clk = ~clk;

    disparity_sweep_ctrl #(.DEPTH_SCALE(SCALE)) dut (
        .clk_in(clk), .rst_in(rst),
        .job_valid_in(job_valid), .job_ready_out(job_ready),
        .hcount_in(hcount), .vcount_in(vcount),
        .sad_start_out(sad_start), .sad_offset_out(sad_offset),
        .sad_hcount_out(sad_hcount), .sad_vcount_out(sad_vcount),
        .sad_done_in(sad_done), .sad_value_in(sad_value),
        .data_valid_out(dv), .pixel_depth_out(depth),
        .hcount_out(hout), .vcount_out(vout), .err_out(err)
    );

    disparity_sweep_ctrl #(.DEPTH_SCALE(SCALE2)) dut_sat (
        .clk_in(clk), .rst_in(rst),
        .job_valid_in(job_valid), .job_ready_out(job_ready2),
        .hcount_in(hcount), .vcount_in(vcount),
        .sad_start_out(sad_start2), .sad_offset_out(sad_offset2),
        .sad_hcount_out(sad_hcount2), .sad_vcount_out(sad_vcount2),
        .sad_done_in(sad_done), .sad_value_in(sad_value),
        .data_valid_out(dv2), .pixel_depth_out(depth2),
        .hcount_out(hout2), .vcount_out(vout2), .err_out(err2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int          cyc = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [15:0] pend_val;
    bit          use_tab = 0;
    int          sad_tab[MAXD];
    int unsigned seed;

    always @(posedge clk) cyc++;

    function automatic int unsigned sad_fn(input int h, input int v,
                                           input int o);
        int unsigned x;
        if (use_tab) return sad_tab[o];
        x = h * 131 + v * 71 + o * 37 + seed;
        x = x ^ (x >> 5);
        return (x * 13) % 29;
    endfunction

    // SAD engine stand-in: done arrives lat cycles after the start cycle.
    always @(posedge clk) begin
        #1;
        sad_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                sad_done  = 1'b1;
                sad_value = pend_val;
            end
        end
        if (sad_start) begin
            cnt      = lat;
            pend_val = 16'(sad_fn(sad_hcount, sad_vcount, sad_offset));
        end
    end

    typedef struct {
        int h; int v; int n; int depth; int depth2; int due;
    } exp_t;

    exp_t q[$];
    int   st_idx, cur_h, cur_v, acc_cyc;
    int   n_res = 0;
    int   last_lat, last_n, last_depth, last_depth2;

    always @(negedge clk) begin
        exp_t e;
        int   bs, bo, s;
        if (!rst) begin
            if (job_valid && job_ready) begin
                e.h = hcount;
                e.v = vcount;
                e.n = (hcount + 1 < MAXD) ? hcount + 1 : MAXD;
                bs = 'hFFFF;
                bo = 0;
                for (int o = 0; o < e.n; o++) begin
                    s = int'(sad_fn(hcount, vcount, o) & 'hFFFF);
                    if (s < bs) begin
                        bs = s;
                        bo = o;
                    end
                end
                e.depth  = (bo * SCALE > 255) ? 255 : bo * SCALE;
                e.depth2 = (bo * SCALE2 > 255) ? 255 : bo * SCALE2;
                e.due    = cyc + 2 + e.n * (lat + 1);
                q.push_back(e);
                st_idx  = 0;
                cur_h   = hcount;
                cur_v   = vcount;
                acc_cyc = cyc;
            end
            if (sad_start) begin
                check("start_off", sad_offset, st_idx);
                check("start_h", sad_hcount, cur_h);
                check("start_v", sad_vcount, cur_v);
                check("busy_ready", job_ready, 0);
                st_idx++;
            end
            if (dv) begin
                n_res++;
                if (q.size() == 0) begin
                    check("spurious_dv", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("depth", depth, e.depth);
                    check("hout", hout, e.h);
                    check("vout", vout, e.v);
                    check("dv_cycle", cyc, e.due);
                    check("n_starts", st_idx, e.n);
                    check("dv_sat", dv2, 1);
                    check("depth_sat", depth2, e.depth2);
                    last_lat    = cyc - acc_cyc;
                    last_n      = st_idx;
                    last_depth  = depth;
                    last_depth2 = depth2;
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (job_ready) return;
        end
        check("ready_timeout", 1, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0) return;
        end
        check("result_timeout", 1, 0);
        q.delete();
    endtask

    task automatic run_job(input int h, input int v);
        wait_ready();
        job_valid = 1'b1;
        hcount    = 11'(h);
        vcount    = 10'(v);
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        wait_done();
    endtask

    int base;
    bit hit;

    initial begin
        rst       = 1'b1;
        job_valid = 1'b0;
        hcount    = '0;
        vcount    = '0;
        seed      = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", job_ready, 1);
        check("rst_start", sad_start, 0);
        check("rst_off", sad_offset, 0);
        check("rst_sadh", sad_hcount, 0);
        check("rst_dv", dv, 0);
        check("rst_depth", depth, 0);
        check("rst_hout", hout, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        use_tab = 1;
        lat     = 3;
        sad_tab = '{50, 40, 30, 5, 60, 70, 80, 90, 100, 110};
        run_job(20, 5);
        check("min_lat", last_lat, 42);
        check("min_n", last_n, 10);
        check("min_depth", last_depth, 75);

        lat = 2;
        foreach (sad_tab[i]) sad_tab[i] = 7;
        run_job(15, 3);
        check("tie_depth", last_depth, 0);

        foreach (sad_tab[i]) sad_tab[i] = $urandom_range(0, 500);
        run_job(2, 7);
        check("edge2_n", last_n, 3);

        lat = 4;
        run_job(0, 1);
        check("edge0_n", last_n, 1);
        check("edge0_lat", last_lat, 7);

        lat = 1;
        foreach (sad_tab[i]) sad_tab[i] = 100 - i;
        run_job(30, 2);
        check("sat_depth", last_depth2, 255);
        check("nosat_depth", last_depth, 225);

        use_tab = 0;
        for (int j = 0; j < 40; j++) begin
            lat = $urandom_range(1, 4);
            if (j % 3 == 0)
                run_job($urandom_range(0, 12), $urandom_range(0, 359));
            else
                run_job($urandom_range(0, 639), $urandom_range(0, 359));
        end
        check("no_err", err, 0);

        lat  = 1;
        base = n_res;
        wait_ready();
        job_valid = 1'b1;
        for (int p = 0; p < 8; p++) begin
            hcount = 11'(p * 3);
            vcount = 10'(9);
            hit    = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                hit = job_ready;
            end
            if (!hit) check("b2b_timeout", 1, 0);
            @(posedge clk);
            #1;
        end
        job_valid = 1'b0;
        wait_done();
        check("b2b_count", n_res - base, 8);

        lat = 5;
        wait_ready();
        job_valid = 1'b1;
        hcount    = 11'd20;
        vcount    = 10'd4;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = sad_start && (sad_offset == 4);
        end
        if (!hit) check("off4_timeout", 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        base = n_res;
        check("rr_ready", job_ready, 1);
        check("rr_err_clr", err, 0);
        repeat (12) @(posedge clk);
        #1;
        check("rr_no_dv", n_res - base, 0);
        check("rr_late_err", err, 1);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("final_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disparity_sweep_ctrl.md
# disparity_sweep_ctrl

Sequences the SAD engine across the disparity search range for each pixel the line buffers present. For each pixel it issues one SAD request per candidate offset and tracks the minimum-cost offset. It then emits a scaled relative-depth byte with the pixel's coordinates. It sits between the stereo line buffers and the depth output path, and owns the SAD engine's start, offset and coordinate inputs.

## Interface
Parameters:
- HRES, 640, active pixels per line
- VRES, 360, active lines per frame
- MAX_DISP, 10, number of candidate offsets (0..MAX_DISP-1)
- SAD_W, 16, SAD result width
- DEPTH_SCALE, 25, multiplier from best offset to depth byte

Ports:
- clk_in  in  1  system clock (100 MHz)
- rst_in  in  1  synchronous, active-high reset
- job_valid_in  in  1  line buffers hold a kernel-ready pixel
- job_ready_out  out  1  controller can accept a pixel job
- hcount_in  in  11  job pixel column
- vcount_in  in  10  job pixel row
- sad_start_out  out  1  one-cycle request pulse to the SAD engine
- sad_offset_out  out  $clog2(MAX_DISP)  offset for the current request
- sad_hcount_out  out  11  latched job column, stable from start to done
- sad_vcount_out  out  10  latched job row, stable from start to done
- sad_done_in  in  1  one-cycle pulse: SAD result valid
- sad_value_in  in  SAD_W  SAD for the requested offset
- data_valid_out  out  1  one-cycle pulse: depth result valid
- pixel_depth_out  out  8  relative depth
- hcount_out  out  11  result column
- vcount_out  out  10  result row
- err_out  out  1  sticky protocol error flag

## Operation
FSM states: IDLE, ISSUE, WAIT, EMIT.
- **IDLE**
  - job_ready_out=1.
  - On job_valid_in && job_ready_out: latch hcount/vcount, offset←0, best_sad←all ones, best_off←0, go to ISSUE.
- **ISSUE**
  - If offset==MAX_DISP or offset>latched hcount, go to EMIT with no request.
  - Otherwise pulse sad_start_out with sad_offset_out=offset, go to WAIT.
- **WAIT**
  - Hold until sad_done_in.
  - If sad_value_in < best_sad (strict), update best_sad and best_off. Ties keep the smaller offset.
  - offset←offset+1, go to ISSUE.
- **EMIT**
  - data_valid_out=1.
  - pixel_depth_out=min(best_off*DEPTH_SCALE, 255), computed in 16 bits, then saturated.
  - hcount_out/vcount_out = latched coordinates.
  - Go to IDLE.

Rules:
- Left edge: hcount=h issues offsets 0..min(h, MAX_DISP-1) only. Right-image column x-d is never negative.
- sad_done_in outside WAIT is ignored for the datapath and sets err_out. err_out clears only on reset.
- No downstream backpressure. The consumer must accept data_valid_out whenever it is pulsed.
- Jobs offered while job_ready_out=0 are not consumed. The upstream source holds job_valid_in.

## Timing
- All outputs are registered.
- Reset values: state IDLE, job_ready_out=1, sad_start_out=0, sad_offset_out=0, sad_hcount_out/sad_vcount_out=0, data_valid_out=0, pixel_depth_out=0, hcount_out=0, vcount_out=0, err_out=0.
- Job accepted at cycle 0: first sad_start_out at cycle 1.
- With SAD latency L (start to done, L≥1), each offset costs L+1 cycles.
- With N issued offsets: data_valid_out at cycle 2+N(L+1). Earliest next accept at cycle 3+N(L+1).
- sad_done_in coinciding with the start cycle (L=0) is not supported. It counts as a stray done and sets err_out.
- Reset mid-job (any state): the in-flight job is dropped, no data_valid_out is produced, state returns to IDLE next cycle. A late sad_done_in after reset sets err_out.

## Structure
- Shared package depth_pkg holds:
  - the FSM state enum;
  - the default MAX_DISP;
  - coordinate widths (11/10).
- One sub-module, sad_min_tracker, holds best_sad/best_off and does the strict-less compare, init and update. Its init/update interface is driven by the FSM.

## Test plan
- **Minimum selection:** hcount=20, vcount=5; SAD for offsets 0..9 = 50,40,30,5,60,70,80,90,100,110, L=3 → 10 starts, depth=75, (20,5) at cycle 42.
- **Tie:** all SADs = 7 → best_off=0, depth=0.
- **Left edge:**
  - hcount=2 → exactly 3 starts (offsets 0,1,2).
  - hcount=0 → 1 start, data_valid_out at cycle 2+(L+1).
- **Saturation:** DEPTH_SCALE=40, best_off=9 → pixel_depth_out=255.
- **Reset mid-WAIT:**
  - Assert rst_in in WAIT at offset 4 → no data_valid_out; job_ready_out=1 the cycle after reset.
  - The delayed sad_done_in then sets err_out.
- **Back-to-back jobs:** job_valid_in held high with consecutive pixels, L=1 → job_ready_out deasserted during each sweep. Every job yields exactly one result, in order, with correct coordinates.
